// File: rtl/smiley_hit_detector_pkg.sv
// Shared constants and types for the smiley/brick overlap detector.
// Edge-bit indices match the bit order of the published HitEdgeCode.
package smiley_hit_detector_pkg;

    localparam int EDGE_BOTTOM = 0;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_LEFT   = 3;
    localparam int NUM_EDGES   = 4;

    localparam int DEF_SPRITE_W       = 32;
    localparam int DEF_SPRITE_H       = 32;
    localparam int DEF_EDGE_W         = 4;
    localparam int DEF_MIN_HIT_PIXELS = 3;

    localparam int EDGE_CNT_W  = 8;
    localparam int TOTAL_CNT_W = 10;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACCUM    = 1'b1
    } state_t;

endpackage

// File: rtl/smiley_hit_detector_hit_sat_counter.sv
// Saturating up-counter with a synchronous load that reloads to the current
// increment (0 or 1), so a pixel landing on the load cycle is not lost.
module hit_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (load) begin
            count <= {{(WIDTH-1){1'b0}}, inc};
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/smiley_hit_detector.sv
// Counts smiley/brick overlap pixels per edge band over a frame and publishes
// the per-edge hit code, total and a one-cycle pulse on the next startOfFrame.
module smiley_hit_detector
    import smiley_hit_detector_pkg::*;
#(
    parameter int SPRITE_W       = DEF_SPRITE_W,
    parameter int SPRITE_H       = DEF_SPRITE_H,
    parameter int EDGE_W         = DEF_EDGE_W,
    parameter int MIN_HIT_PIXELS = DEF_MIN_HIT_PIXELS
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        smileyDR,
    input  logic        brickDR,
    input  logic [10:0] offsetX,
    input  logic [10:0] offsetY,
    output logic        collision,
    output logic [3:0]  HitEdgeCode,
    output logic        collisionPulse,
    output logic [9:0]  overlapCount
);

    localparam logic [10:0] BOTTOM_TH = 11'(SPRITE_H - EDGE_W);
    localparam logic [10:0] RIGHT_TH  = 11'(SPRITE_W - EDGE_W);
    localparam logic [10:0] NEAR_TH   = 11'(EDGE_W);
    localparam logic [EDGE_CNT_W-1:0] MIN_HIT = EDGE_CNT_W'(MIN_HIT_PIXELS);

    state_t                   state;
    logic                     overlap;
    logic [NUM_EDGES-1:0]     band;
    logic [NUM_EDGES-1:0]     edge_inc;
    logic [NUM_EDGES-1:0]     hit_now;
    logic [EDGE_CNT_W-1:0]    edge_cnt [NUM_EDGES];
    logic [TOTAL_CNT_W-1:0]   total_cnt;

    // Overlaps before the first frame boundary are ignored; the boundary
    // itself then reloads every counter to zero.
    assign overlap = smileyDR && brickDR && (state == ACCUM);

    always_comb begin
        band              = '0;
        band[EDGE_BOTTOM] = (offsetY >= BOTTOM_TH);
        band[EDGE_TOP]    = (offsetY <  NEAR_TH);
        band[EDGE_RIGHT]  = (offsetX >= RIGHT_TH);
        band[EDGE_LEFT]   = (offsetX <  NEAR_TH);
    end

    assign edge_inc = band & {NUM_EDGES{overlap}};

    for (genvar i = 0; i < NUM_EDGES; i++) begin : g_edge
        hit_sat_counter #(.WIDTH(EDGE_CNT_W)) u_edge_cnt (
            .clk    (clk),
            .resetN (resetN),
            .load   (startOfFrame),
            .inc    (edge_inc[i]),
            .count  (edge_cnt[i])
        );
    end

    hit_sat_counter #(.WIDTH(TOTAL_CNT_W)) u_total_cnt (
        .clk    (clk),
        .resetN (resetN),
        .load   (startOfFrame),
        .inc    (overlap),
        .count  (total_cnt)
    );

    always_comb begin
        hit_now = '0;
        for (int i = 0; i < NUM_EDGES; i++) begin
            hit_now[i] = (edge_cnt[i] >= MIN_HIT);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= WAIT_SOF;
            collision      <= 1'b0;
            HitEdgeCode    <= '0;
            collisionPulse <= 1'b0;
            overlapCount   <= '0;
        end else begin
            collisionPulse <= 1'b0;
            if (startOfFrame) begin
                case (state)
                    WAIT_SOF: state <= ACCUM;
                    ACCUM: begin
                        HitEdgeCode    <= hit_now;
                        collision      <= |hit_now;
                        overlapCount   <= total_cnt;
                        collisionPulse <= |hit_now;
                    end
                    default: state <= WAIT_SOF;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_smiley_hit_detector.sv
// Directed-vector bench for smiley_hit_detector with hand-computed expectations.
module tb_smiley_hit_detector;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        smileyDR = 1'b0;
    logic        brickDR = 1'b0;
    logic [10:0] offsetX = '0;
    logic [10:0] offsetY = '0;
    logic        collision;
    logic [3:0]  HitEdgeCode;
    logic        collisionPulse;
    logic [9:0]  overlapCount;

    int vectors = 0;
    int miscompares = 0;

    smiley_hit_detector dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .smileyDR       (smileyDR),
        .brickDR        (brickDR),
        .offsetX        (offsetX),
        .offsetY        (offsetY),
        .collision      (collision),
        .HitEdgeCode    (HitEdgeCode),
        .collisionPulse (collisionPulse),
        .overlapCount   (overlapCount)
    );

    always #5 clk = ~clk;

    // n cycles of drawing at (x,y); brick selects whether it is an overlap
    task automatic drive_pixels(input int x, input int y, input int n, input logic brick);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            smileyDR = 1'b1;
            brickDR  = brick;
            offsetX  = 11'(x);
            offsetY  = 11'(y);
        end
        @(negedge clk);
        smileyDR = 1'b0;
        brickDR  = 1'b0;
    endtask

    // one-cycle startOfFrame, optionally with an overlap pixel on the same cycle;
    // returns at the negedge right after the publishing posedge
    task automatic frame_start(input logic with_pix, input int x, input int y);
        @(negedge clk);
        startOfFrame = 1'b1;
        smileyDR     = with_pix;
        brickDR      = with_pix;
        offsetX      = 11'(x);
        offsetY      = 11'(y);
        @(negedge clk);
        startOfFrame = 1'b0;
        smileyDR     = 1'b0;
        brickDR      = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        #12;
        vectors++;
        if (collision !== 1'b0) begin miscompares++; $display("FAIL reset_collision got=%b want=0", collision); end
        vectors++;
        if (HitEdgeCode !== 4'b0000) begin miscompares++; $display("FAIL reset_code got=%b want=0000", HitEdgeCode); end
        vectors++;
        if (collisionPulse !== 1'b0) begin miscompares++; $display("FAIL reset_pulse got=%b want=0", collisionPulse); end
        vectors++;
        if (overlapCount !== 10'd0) begin miscompares++; $display("FAIL reset_count got=%0d want=0", overlapCount); end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_bottom_hit();
        // overlaps before the first frame boundary must be ignored
        drive_pixels(16, 31, 4, 1'b1);
        frame_start(1'b0, 0, 0);
        vectors++;
        if (HitEdgeCode !== 4'b0000 || overlapCount !== 10'd0 || collisionPulse !== 1'b0) begin
            miscompares++;
            $display("FAIL first_sof_publish got code=%b cnt=%0d pulse=%b want 0000/0/0", HitEdgeCode, overlapCount, collisionPulse);
        end
        drive_pixels(16, 31, 10, 1'b1);
        frame_start(1'b0, 0, 0);
        vectors++;
        if (HitEdgeCode !== 4'b0001) begin miscompares++; $display("FAIL bottom_code got=%b want=0001", HitEdgeCode); end
        vectors++;
        if (collision !== 1'b1) begin miscompares++; $display("FAIL bottom_collision got=%b want=1", collision); end
        vectors++;
        if (collisionPulse !== 1'b1) begin miscompares++; $display("FAIL bottom_pulse got=%b want=1", collisionPulse); end
        vectors++;
        if (overlapCount !== 10'd10) begin miscompares++; $display("FAIL bottom_count got=%0d want=10", overlapCount); end
        @(negedge clk);
        vectors++;
        if (collisionPulse !== 1'b0) begin miscompares++; $display("FAIL bottom_pulse_width got=%b want=0", collisionPulse); end
        vectors++;
        if (HitEdgeCode !== 4'b0001 || collision !== 1'b1) begin
            miscompares++;
            $display("FAIL bottom_hold got code=%b coll=%b want 0001/1", HitEdgeCode, collision);
        end
    endtask

    task automatic test_below_threshold();
        drive_pixels(0, 10, 2, 1'b1);
        frame_start(1'b0, 0, 0);
        vectors++;
        if (HitEdgeCode !== 4'b0000 || collision !== 1'b0) begin
            miscompares++;
            $display("FAIL left_thresh got code=%b coll=%b want 0000/0", HitEdgeCode, collision);
        end
        vectors++;
        if (collisionPulse !== 1'b0) begin miscompares++; $display("FAIL left_pulse got=%b want=0", collisionPulse); end
        vectors++;
        if (overlapCount !== 10'd2) begin miscompares++; $display("FAIL left_count got=%0d want=2", overlapCount); end
    endtask

    task automatic test_corner();
        drive_pixels(31, 0, 4, 1'b0);   // smiley without brick: not an overlap
        drive_pixels(31, 0, 5, 1'b1);
        frame_start(1'b0, 0, 0);
        vectors++;
        if (HitEdgeCode !== 4'b0110) begin miscompares++; $display("FAIL corner_code got=%b want=0110", HitEdgeCode); end
        vectors++;
        if (collision !== 1'b1 || collisionPulse !== 1'b1) begin
            miscompares++;
            $display("FAIL corner_coll got coll=%b pulse=%b want 1/1", collision, collisionPulse);
        end
        vectors++;
        if (overlapCount !== 10'd5) begin miscompares++; $display("FAIL corner_count got=%0d want=5", overlapCount); end
    endtask

    task automatic test_total_saturate();
        drive_pixels(16, 16, 1100, 1'b1);
        frame_start(1'b0, 0, 0);
        vectors++;
        if (overlapCount !== 10'd1023) begin miscompares++; $display("FAIL sat_count got=%0d want=1023", overlapCount); end
        vectors++;
        if (HitEdgeCode !== 4'b0000 || collision !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_code got code=%b coll=%b want 0000/0", HitEdgeCode, collision);
        end
    endtask

    task automatic test_sof_overlap();
        // previous frame was empty; the coincident pixel seeds the new frame
        frame_start(1'b1, 16, 31);
        vectors++;
        if (HitEdgeCode !== 4'b0000 || overlapCount !== 10'd0) begin
            miscompares++;
            $display("FAIL sofpix_prev got code=%b cnt=%0d want 0000/0", HitEdgeCode, overlapCount);
        end
        drive_pixels(16, 31, 2, 1'b1);
        frame_start(1'b0, 0, 0);
        vectors++;
        if (HitEdgeCode !== 4'b0001) begin miscompares++; $display("FAIL sofpix_code got=%b want=0001", HitEdgeCode); end
        vectors++;
        if (overlapCount !== 10'd3) begin miscompares++; $display("FAIL sofpix_count got=%0d want=3", overlapCount); end
    endtask

    task automatic test_reset_mid_frame();
        drive_pixels(16, 31, 8, 1'b1);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        vectors++;
        if (HitEdgeCode !== 4'b0000 || collision !== 1'b0 || overlapCount !== 10'd0 || collisionPulse !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs got code=%b coll=%b cnt=%0d pulse=%b want all 0", HitEdgeCode, collision, overlapCount, collisionPulse);
        end
        @(negedge clk);
        resetN = 1'b1;
        drive_pixels(16, 31, 2, 1'b1);
        frame_start(1'b0, 0, 0);
        vectors++;
        if (HitEdgeCode !== 4'b0000 || overlapCount !== 10'd0 || collisionPulse !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_first_sof got code=%b cnt=%0d pulse=%b want 0000/0/0", HitEdgeCode, overlapCount, collisionPulse);
        end
        drive_pixels(16, 31, 3, 1'b1);
        frame_start(1'b0, 0, 0);
        vectors++;
        if (HitEdgeCode !== 4'b0001 || overlapCount !== 10'd3) begin
            miscompares++;
            $display("FAIL midrst_report got code=%b cnt=%0d want 0001/3", HitEdgeCode, overlapCount);
        end
    endtask

    initial begin
        test_reset();
        test_bottom_hit();
        test_below_threshold();
        test_corner();
        test_total_saturate();
        test_sof_overlap();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
